// File: rtl/rng_pkg.sv
// Shared types and constants for the dice-style roller.
package rng_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ROLL = 1'b1
  } state_e;

  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; steps every clock.
module lfsr16
  import rng_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] q
);

  // Shift right; when the bit falling out is 1, fold in the tap mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= LFSR_SEED;
    end else begin
      q <= q[0] ? ((q >> 1) ^ LFSR_MASK) : (q >> 1);
    end
  end

endmodule

// File: rtl/rng_roller.sv
// Dice roller: decelerating display sequence plus indexed store/recall slots.
//
// Input handshake: i_start and i_store carry no valid/ready pairing; each
// acts on its rising edge only (current high while the registered previous
// value is low), so holding a key down produces a single event.
module rng_roller
  import rng_pkg::*;
#(
  parameter int  WIDTH    = 4,
  parameter int  SLOTS    = 4,
  parameter int  STEPS    = 16,
  parameter int  BASE_DIV = 500000,
  localparam int IW       = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_store,
  input  logic [IW-1:0]    i_index,
  output logic [WIDTH-1:0] o_random_out,
  output logic [WIDTH-1:0] o_stored_out,
  output logic             o_busy,
  output logic             o_done,
  output state_e           o_state
);

  localparam int CW = (BASE_DIV * STEPS > 1) ? $clog2(BASE_DIV * STEPS) : 1;
  localparam int SW = $clog2(STEPS + 1);
  localparam logic [SW-1:0] LAST_STEP = SW'(STEPS - 1);

  logic [15:0]      lfsr_q;
  logic             unused_lfsr;
  state_e           state;
  state_e           state_nxt;
  logic             start_prev;
  logic             store_prev;
  logic             start_ev;
  logic             store_ev;
  logic [CW-1:0]    cnt;
  logic [SW-1:0]    step;
  logic [31:0]      limit;
  logic             step_hit;
  logic             step_last;
  logic             idx_ok;
  logic             wr_en;
  logic [WIDTH-1:0] mem [SLOTS];

  lfsr16 u_lfsr (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .q     (lfsr_q)
  );

  // Only the low WIDTH bits are displayed; the rest just keep the sequence long.
  assign unused_lfsr = ^lfsr_q;

  assign start_ev  = i_start & ~start_prev;
  assign store_ev  = i_store & ~store_prev;
  // Step k lasts BASE_DIV*(k+1) cycles, so the display slows each step.
  assign limit     = 32'(BASE_DIV) * (32'(step) + 32'd1) - 32'd1;
  assign step_hit  = (32'(cnt) == limit);
  assign step_last = (step == LAST_STEP);
  assign idx_ok    = (32'(i_index) < 32'(SLOTS));
  // Stores are only honoured while idle; the pre-roll value is captured even
  // when a start arrives in the same cycle.
  assign wr_en     = store_ev & (state == S_IDLE) & idx_ok;

  // Previous-value flops for rising-edge detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      start_prev <= 1'b0;
      store_prev <= 1'b0;
    end else begin
      start_prev <= i_start;
      store_prev <= i_store;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: a start always (re)enters ROLL; the last update leaves it.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (start_ev) state_nxt = S_ROLL;
      S_ROLL: if (!start_ev && step_hit && step_last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    o_busy  = (state == S_ROLL);
    o_state = state;
  end

  // Step timer and display register; a restart wins over a coincident update.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt          <= '0;
      step         <= '0;
      o_random_out <= '0;
      o_done       <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (start_ev) begin
        cnt  <= '0;
        step <= '0;
      end else if (state == S_ROLL) begin
        if (step_hit) begin
          o_random_out <= lfsr_q[WIDTH-1:0];
          cnt          <= '0;
          step         <= step + 1'b1;
          o_done       <= step_last;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  // Slot memory, plain flops.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < SLOTS; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[i_index] <= o_random_out;
    end
  end

  // Registered recall with write-through; out-of-range slots read as zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_stored_out <= '0;
    end else if (!idx_ok) begin
      o_stored_out <= '0;
    end else if (wr_en) begin
      o_stored_out <= o_random_out;
    end else begin
      o_stored_out <= mem[i_index];
    end
  end

endmodule

// File: tb/tb_rng_roller.sv
// Bench for rng_roller: a default-slot instance and a 3-slot instance share
// the same stimulus; a reference model predicts every output each cycle.
module tb_rng_roller;
  import rng_pkg::*;

  localparam int W        = 4;
  localparam int SLOTS_A  = 4;
  localparam int SLOTS_B  = 3;
  localparam int STEPS    = 16;
  localparam int BASE_DIV = 4;
  localparam int IW       = 2;

  typedef struct {
    int         edge_n;
    int         start_edge;
    logic [W-1:0] val;
    bit         last;
  } upd_t;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_start = 1'b0;
  logic          i_store = 1'b0;
  logic [IW-1:0] i_index = '0;
  logic [W-1:0]  rnd_a, sto_a, rnd_b, sto_b;
  logic          busy_a, done_a, busy_b, done_b;
  state_e        state_a, state_b;

  always #5 clk = ~clk;

  rng_roller #(.WIDTH(W), .SLOTS(SLOTS_A), .STEPS(STEPS), .BASE_DIV(BASE_DIV)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_store(i_store), .i_index(i_index),
    .o_random_out(rnd_a), .o_stored_out(sto_a), .o_busy(busy_a), .o_done(done_a),
    .o_state(state_a)
  );

  rng_roller #(.WIDTH(W), .SLOTS(SLOTS_B), .STEPS(STEPS), .BASE_DIV(BASE_DIV)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_store(i_store), .i_index(i_index),
    .o_random_out(rnd_b), .o_stored_out(sto_b), .o_busy(busy_b), .o_done(done_b),
    .o_state(state_b)
  );

  // ---------------- bookkeeping ----------------
  int tests = 0;
  int fails = 0;
  int cyc;
  logic          smp_start, smp_store;
  logic [IW-1:0] smp_idx;

  // Edges since reset release, and the inputs the DUT saw at the latest edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(posedge clk) begin
    smp_start <= i_start;
    smp_store <= i_store;
    smp_idx   <= i_index;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  upd_t         exp_q[$];
  logic [W-1:0] m_disp;
  logic [W-1:0] mem_a [SLOTS_A];
  logic [W-1:0] mem_b [SLOTS_B];
  logic         m_start_p, m_store_p;

  function automatic logic [15:0] lfsr_at(input int n);
    logic [15:0] q;
    q = 16'hACE1;
    for (int i = 0; i < n; i++) q = q[0] ? ((q >> 1) ^ 16'hB400) : (q >> 1);
    return q;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    m_disp    = '0;
    m_start_p = 1'b0;
    m_store_p = 1'b0;
    for (int i = 0; i < SLOTS_A; i++) mem_a[i] = '0;
    for (int i = 0; i < SLOTS_B; i++) mem_b[i] = '0;
  endtask

  // Evaluate what should be visible after edge e and compare both instances.
  task automatic model_step();
    int           e;
    bit           act_before, st_ev, sr_ev, done_e, busy_e;
    upd_t         u;
    logic [15:0]  lq;
    logic [W-1:0] exp_sa, exp_sb;
    e = cyc;
    act_before = (exp_q.size() > 0) && (exp_q[0].start_edge < e);
    st_ev = smp_store && !m_store_p;
    sr_ev = smp_start && !m_start_p;
    m_store_p = smp_store;
    m_start_p = smp_start;
    if (st_ev && !act_before) begin
      if (int'(smp_idx) < SLOTS_A) mem_a[smp_idx] = m_disp;
      if (int'(smp_idx) < SLOTS_B) mem_b[smp_idx] = m_disp;
    end
    if (sr_ev) begin
      exp_q.delete();
      for (int k = 1; k <= STEPS; k++) begin
        u.edge_n     = e + BASE_DIV * k * (k + 1) / 2;
        u.start_edge = e;
        lq           = lfsr_at(u.edge_n - 1);
        u.val        = lq[W-1:0];
        u.last       = (k == STEPS);
        exp_q.push_back(u);
      end
    end
    done_e = 1'b0;
    if (exp_q.size() > 0 && exp_q[0].edge_n == e) begin
      u      = exp_q.pop_front();
      m_disp = u.val;
      done_e = u.last;
    end
    busy_e = (exp_q.size() > 0) && (exp_q[0].start_edge <= e);
    exp_sa = (int'(smp_idx) < SLOTS_A) ? mem_a[smp_idx] : '0;
    exp_sb = (int'(smp_idx) < SLOTS_B) ? mem_b[smp_idx] : '0;
    chk("random_a", 16'(rnd_a), 16'(m_disp));
    chk("done_a",   16'(done_a), 16'(done_e));
    chk("busy_a",   16'(busy_a), 16'(busy_e));
    chk("state_a",  16'(state_a == S_ROLL), 16'(busy_e));
    chk("stored_a", 16'(sto_a), 16'(exp_sa));
    chk("random_b", 16'(rnd_b), 16'(m_disp));
    chk("done_b",   16'(done_b), 16'(done_e));
    chk("busy_b",   16'(busy_b), 16'(busy_e));
    chk("stored_b", 16'(sto_b), 16'(exp_sb));
  endtask

  // Monitor: runs the model after every active edge while out of reset.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && cyc > 0) model_step();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_random_a", 16'(rnd_a), 16'h0);
    chk("rst_stored_a", 16'(sto_a), 16'h0);
    chk("rst_busy_a",   16'(busy_a), 16'h0);
    chk("rst_done_a",   16'(done_a), 16'h0);
    chk("rst_random_b", 16'(rnd_b), 16'h0);
    chk("rst_stored_b", 16'(sto_b), 16'h0);
    chk("rst_busy_b",   16'(busy_b), 16'h0);
    chk("rst_done_b",   16'(done_b), 16'h0);
  endtask

  // Asynchronous reset placed mid-cycle, away from both clock edges.
  task automatic do_reset();
    @(negedge clk);
    #2;
    i_start = 1'b0;
    i_store = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk_reset_outputs();
    model_clear();
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic pulse_start(input int hold);
    i_start = 1'b1;
    repeat (hold) tick();
    i_start = 1'b0;
  endtask

  task automatic pulse_store(input int idx);
    i_index = IW'(idx);
    i_store = 1'b1;
    tick();
    i_store = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    tests++;
    if (exp_q.size() > 0) begin
      fails++;
      $display("FAIL roll_timeout cyc=%0d pending=%0d budget=%0d", cyc, exp_q.size(), budget);
    end
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_clear();
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (5) tick();

    // Store before any roll, then a full roll with start held two cycles.
    pulse_store(2);
    pulse_start(2);
    wait_idle(700);

    // Capture the rolled value into slot 2, then sweep recall.
    pulse_store(2);
    for (int i = 0; i < 4; i++) begin
      i_index = IW'(i);
      tick();
    end

    // Restart at step 5; stores during the roll must be ignored.
    pulse_start(1);
    repeat (BASE_DIV * 15 + 1) tick();
    pulse_start(1);
    repeat (10) tick();
    pulse_store(1);
    repeat (7) tick();
    pulse_store(0);
    wait_idle(700);
    for (int i = 0; i < 4; i++) begin
      i_index = IW'(i);
      tick();
    end

    // Index 3 is out of range for the 3-slot instance.
    pulse_store(3);
    repeat (3) tick();

    // Store and start in the same idle cycle.
    i_index = 2'd1;
    i_store = 1'b1;
    i_start = 1'b1;
    tick();
    i_store = 1'b0;
    i_start = 1'b0;
    wait_idle(700);
    repeat (2) tick();

    // Randomised rolls, restarts, stores and index changes.
    for (int it = 0; it < 8; it++) begin
      i_index = IW'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) pulse_store(int'(i_index));
      if ($urandom_range(0, 3) == 0) i_store = 1'b1;
      pulse_start($urandom_range(1, 4));
      i_store = 1'b0;
      for (int c = 0; c < int'($urandom_range(0, 400)); c++) begin
        if ($urandom_range(0, 15) == 0) i_store = ~i_store;
        if ($urandom_range(0, 31) == 0) i_index = IW'($urandom_range(0, 3));
        if ($urandom_range(0, 199) == 0) i_start = ~i_start;
        tick();
      end
      i_start = 1'b0;
      i_store = 1'b0;
      wait_idle(700);
      for (int i = 0; i < 4; i++) begin
        i_index = IW'(i);
        tick();
      end
    end

    // Reset at step 8 aborts the roll; nothing may follow for 1000 cycles.
    pulse_start(1);
    repeat (BASE_DIV * 36 + 1) tick();
    do_reset();
    for (int c = 0; c < 1000; c++) begin
      i_index = IW'(c % 4);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rng_roller.md
# rng_roller

Parametrised dice-style random-number roller with a decelerating display sequence and an indexed store/recall memory. It is the successor to the Lab1 4-bit roller, generalised in output width, slot count, step count and step timing. It sits between the board's debounced key inputs and the seven-segment decoders. A free-running LFSR supplies values, and each roll slows down step by step until it settles on a final value.

## Interface
Parameters:
- WIDTH, 4, output value width; legal range 1..16.
- SLOTS, 4, number of store/recall slots; ≥1, need not be a power of 2.
- STEPS, 16, number of display updates per roll; ≥1.
- BASE_DIV, 500000, base step interval in clocks; 10 ms at 50 MHz.

Ports:
- i_clk  in  1  system clock; one clock domain only.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_start  in  1  roll request; rising edge is significant.
- i_store  in  1  store request; rising edge is significant.
- i_index  in  IW = max(1,$clog2(SLOTS))  slot select for store and recall.
- o_random_out  out  WIDTH  current displayed value.
- o_stored_out  out  WIDTH  contents of slot i_index, registered.
- o_busy  out  1  high while rolling.
- o_done  out  1  one-cycle pulse issued with the final roll value.

## Operation
- LFSR:
  - 16-bit Galois, mask 16'hB400, reset seed 16'hACE1.
  - Advances every cycle regardless of state.
  - Sampled value is lfsr[WIDTH-1:0].
- Edge detect: a registered previous-value flop on i_start and on i_store. An event is cur=1 with prev=0. Holding an input high produces one event.
- FSM states are IDLE and ROLL.
- IDLE → ROLL on a start event. On entry: step=0, cnt=0.
- In ROLL, each cycle:
  - If cnt == BASE_DIV*(step+1)-1: o_random_out ← LFSR sample, cnt ← 0, step ← step+1.
  - Otherwise cnt ← cnt+1.
- The update with step == STEPS-1 also sets o_done=1 for that cycle and returns the FSM to IDLE.
- Step k interval is BASE_DIV*(k+1) cycles, so the display visibly slows.
- Start event during ROLL: restart. step=0, cnt=0, o_random_out unchanged, no o_done.
- Store event in IDLE: slot[i_index] ← o_random_out. Store events during ROLL are ignored.
- Store and start events in the same IDLE cycle: the store captures the pre-roll o_random_out, and the roll starts.
- Recall: o_stored_out ← mem[i_index] every cycle. On a store to the selected slot, it takes the written value (write-through).
- i_index ≥ SLOTS: writes are ignored and o_stored_out reads 0.
- Widths:
  - cnt is $clog2(BASE_DIV*STEPS) bits.
  - step is max(1,$clog2(STEPS+1)) bits.
  - No overflow is possible within the legal ranges.

## Timing
- Reset values:
  - o_random_out=0, o_stored_out=0, o_busy=0, o_done=0.
  - All slots 0, FSM IDLE, edge flops 0, LFSR=16'hACE1.
- Reset mid-roll aborts immediately. No o_done follows release.
- Start event sampled at edge t: o_busy=1 from edge t+1.
- First update lands BASE_DIV cycles after o_busy rises.
- The final update lands BASE_DIV*STEPS*(STEPS+1)/2 cycles after o_busy rises. At that edge o_done=1 and o_busy=0.
- Store or index change sampled at edge t is reflected on o_stored_out after edge t+1. Latency is 1 cycle.
- o_random_out changes only on update edges.

## Structure
- Package rng_pkg holds:
  - the state enum {S_IDLE, S_ROLL};
  - LFSR_MASK = 16'hB400;
  - LFSR_SEED = 16'hACE1.
- Sub-module lfsr16 (clk, rst_n, q[15:0]) is free-running and instantiated once.
- Slot memory is a flop array, SLOTS×WIDTH, with no RAM inference needed.

## Test plan
Run all tests with BASE_DIV=4 and other parameters at default; a full roll then takes 4*136 = 544 cycles.
1. Reset with inputs idle → all outputs 0. After release, the LFSR model matches the DUT's sampled values.
2. i_start high for 2 cycles → o_busy rises next cycle. Exactly 16 updates occur, at offsets 4, 12, 24, …, 544. Each value equals the model's lfsr[3:0]. One o_done pulse appears at 544.
3. Second start event at step 5 → step resets. The only o_done arrives 544 cycles after the second busy-relative origin.
4. IDLE with o_random_out=V, i_index=2, one i_store pulse → o_stored_out=V one cycle later. i_index=0 → 0. A store attempted during ROLL leaves all slots unchanged.
5. SLOTS=3, i_index=3 with store → no slot changes and o_stored_out=0.
6. i_rst_n pulsed low at step 8 → all outputs 0 asynchronously, slots cleared, and no o_done for 1000 cycles after release.
